// File: rtl/xyz_step_sequencer_if.sv
// Load/run request and datapath observation bundle for xyz_step_sequencer.
// The master drives requests and load values; the slave returns the register state and status.
interface xyz_step_sequencer_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             mode;
    logic [W-1:0]     x_init;
    logic [W-1:0]     y_init;
    logic [W-1:0]     z_init;
    logic [CNT_W-1:0] n_steps;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [W-1:0]     z;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, x_init, y_init, z_init, n_steps,
        input  x, y, z, step_cnt, busy, done
    );

    modport slave (
        input  start, mode, x_init, y_init, z_init, n_steps,
        output x, y, z, step_cnt, busy, done
    );
endinterface

// File: rtl/xyz_step_sequencer.sv
// Sequences the x/y/z update datapath: load on start, run n_steps updates in
// parallel or ordered semantics, then pulse done for one cycle.
module xyz_step_sequencer #(
    parameter int unsigned W       = 8,
    parameter int unsigned X_CONST = 25,
    parameter int unsigned Y_ADD   = 13,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    xyz_step_sequencer_if.slave bus
);
    localparam int unsigned PW = 2 * W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [W-1:0] XC = W'(X_CONST);
    localparam logic [W-1:0] YA = W'(Y_ADD);

    logic [1:0]       state, state_nxt;
    logic [W-1:0]     x_q, y_q, z_q;
    logic [W-1:0]     x_nxt, y_nxt, z_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic             mode_q, mode_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;

    // Both semantics computed side by side; the latched mode picks one per step
    logic [W-1:0]  y_par, y_ord;
    logic [PW-1:0] z_par_full, z_ord_full;

    always_comb begin
        y_par      = x_q + YA;
        z_par_full = PW'(x_q) * PW'(y_q);
        y_ord      = XC + YA;
        z_ord_full = PW'(XC) * PW'(y_ord);
        cnt_inc    = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            z_q    <= z_nxt;
            cnt_q  <= cnt_nxt;
            n_q    <= n_nxt;
            mode_q <= mode_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        z_nxt     = z_q;
        cnt_nxt   = cnt_q;
        n_nxt     = n_q;
        mode_nxt  = mode_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    x_nxt     = bus.x_init;
                    y_nxt     = bus.y_init;
                    z_nxt     = bus.z_init;
                    cnt_nxt   = '0;
                    n_nxt     = bus.n_steps;
                    mode_nxt  = bus.mode;
                    state_nxt = (bus.n_steps != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                x_nxt   = XC;
                cnt_nxt = cnt_inc;
                if (mode_q) begin
                    y_nxt = y_ord;
                    z_nxt = z_ord_full[W-1:0];
                end else begin
                    y_nxt = y_par;
                    z_nxt = z_par_full[W-1:0];
                end
                if (cnt_inc == n_q) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Status is registered alongside the state it reflects
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.z        = z_q;
    assign bus.step_cnt = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
